// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display fetch has absolute priority over a
// small host write FIFO; both share one single-port RAM, one access per cycle.
module vga_fb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic        clk25mhz,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic [11:0] disp_x,
  input  logic [11:0] disp_y,
  output logic [11:0] pix_rgb,
  output logic        pix_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_x,
  input  logic [11:0] wr_y,
  input  logic [11:0] wr_data,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [4:0]  fifo_level,
  output logic        drop_flag
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = 5;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } grant_t;

  // Linear frame-buffer address, truncated to the RAM address width.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [11:0] x, input logic [11:0] y);
    return ADDR_W'(32'(y) * 32'(H_ACTIVE) + 32'(x));
  endfunction

  wr_entry_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full;
  logic               disp_hit, wr_in_range, wr_acc, push, pop;
  grant_t             grant_d, grant_q;
  wr_entry_t          head;
  logic               disp_v1, disp_v2, disp_g2;

  assign disp_hit    = disp_en && (32'(disp_x) < H_ACTIVE) && (32'(disp_y) < V_ACTIVE);
  assign wr_in_range = (32'(wr_x) < H_ACTIVE) && (32'(wr_y) < V_ACTIVE);
  assign full        = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign wr_ready    = rst_n && !full;
  assign wr_acc      = wr_valid && wr_ready;
  assign push        = wr_acc && wr_in_range;
  assign head        = fifo_mem[rd_ptr];

  // Grant state register, re-decided every cycle with no lock.
  always_ff @(posedge clk25mhz) begin
    if (!rst_n) grant_q <= GNT_NONE;
    else        grant_q <= grant_d;
  end

  // Next grant: display first, then FIFO head; pop only with a WR grant.
  always_comb begin
    grant_d = GNT_NONE;
    pop     = 1'b0;
    if (disp_hit) begin
      grant_d = GNT_DISP;
    end else if (fifo_level != '0) begin
      grant_d = GNT_WR;
      pop     = 1'b1;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk25mhz) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: fb_addr(wr_x, wr_y), data: wr_data};
  end

  // FIFO pointers, occupancy and sticky drop indication.
  always_ff @(posedge clk25mhz) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_flag  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (wr_acc && !wr_in_range) drop_flag <= 1'b1;
    end
  end

  // RAM port registers for the grant decided this cycle; address holds when idle.
  always_ff @(posedge clk25mhz) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (grant_d)
        GNT_DISP: mem_addr <= fb_addr(disp_x, disp_y);
        GNT_WR: begin
          mem_addr  <= head.addr;
          mem_we    <= 1'b1;
          mem_wdata <= head.data;
        end
        default: mem_addr <= mem_addr;
      endcase
    end
  end

  // Three-stage pixel return: request, RAM address, RAM data, registered pixel.
  always_ff @(posedge clk25mhz) begin
    if (!rst_n) begin
      disp_v1   <= 1'b0;
      disp_v2   <= 1'b0;
      disp_g2   <= 1'b0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      disp_v1   <= disp_en;
      disp_v2   <= disp_v1;
      disp_g2   <= (grant_q == GNT_DISP);
      pix_valid <= disp_v2;
      pix_rgb   <= disp_g2 ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios then random traffic against
// a cycle-indexed reference model of the arbitration rules.
module tb_vga_fb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HA    = 640;
  localparam int unsigned VA    = 480;

  logic        clk25mhz = 1'b0;
  logic        rst_n;
  logic        disp_en;
  logic [11:0] disp_x, disp_y;
  logic [11:0] pix_rgb;
  logic        pix_valid;
  logic        wr_valid, wr_ready;
  logic [11:0] wr_x, wr_y, wr_data;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [4:0]  fifo_level;
  logic        drop_flag;

  vga_fb_arbiter #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk25mhz(clk25mhz), .rst_n(rst_n),
    .disp_en(disp_en), .disp_x(disp_x), .disp_y(disp_y),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .drop_flag(drop_flag)
  );

  always #20 clk25mhz = ~clk25mhz;

  // RAM contents seen by reads: a fixed pattern of the address.
  function automatic logic [11:0] ram_f(input logic [18:0] a);
    if (a == 19'd1285) return 12'hABC;
    return 12'((32'(a) * 13) ^ (32'(a) >> 5));
  endfunction

  always @(posedge clk25mhz) mem_rdata <= ram_f(mem_addr);

  typedef struct {
    logic [18:0] a;
    logic [11:0] d;
  } ent_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  ent_t        m_q[$];
  logic        m_drop = 1'b0;
  logic [18:0] m_addr = '0;
  logic        exp_we  [int];
  logic [18:0] exp_addr[int];
  logic [11:0] exp_wd  [int];
  logic        exp_pv  [int];
  logic [11:0] exp_rgb [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock: predict effects of current inputs, then check outputs.
  task automatic tick();
    logic hit, in_rng;
    ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_drop = 1'b0;
      m_addr = '0;
      exp_we[cyc+1] = 1'b0; exp_addr[cyc+1] = '0; exp_wd[cyc+1] = '0;
      for (int k = 1; k <= 3; k++) begin
        exp_pv[cyc+k] = 1'b0; exp_rgb[cyc+k] = '0;
      end
    end else begin
      hit = disp_en && (32'(disp_x) < HA) && (32'(disp_y) < VA);
      exp_pv[cyc+3]  = disp_en;
      exp_rgb[cyc+3] = hit ? ram_f(19'(32'(disp_y) * HA + 32'(disp_x))) : 12'h000;
      exp_we[cyc+1]  = 1'b0;
      if (hit) begin
        m_addr = 19'(32'(disp_y) * HA + 32'(disp_x));
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_addr = e.a;
        exp_we[cyc+1] = 1'b1;
        exp_wd[cyc+1] = e.d;
      end
      exp_addr[cyc+1] = m_addr;
      // Ready reflects occupancy before this cycle's pop.
      if (wr_valid && (m_q.size() + ((exp_we[cyc+1]) ? 1 : 0)) < DEPTH) begin
        in_rng = (32'(wr_x) < HA) && (32'(wr_y) < VA);
        if (in_rng) m_q.push_back('{a: 19'(32'(wr_y) * HA + 32'(wr_x)), d: wr_data});
        else        m_drop = 1'b1;
      end
    end
    @(posedge clk25mhz);
    #1;
    cyc++;
    if (exp_we.exists(cyc)) begin
      chk("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
      if (exp_wd.exists(cyc)) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd[cyc]));
    end
    if (exp_pv.exists(cyc)) begin
      chk("pix_valid", 32'(pix_valid), 32'(exp_pv[cyc]));
      chk("pix_rgb", 32'(pix_rgb), 32'(exp_rgb[cyc]));
    end
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("wr_ready", 32'(wr_ready), 32'(rst_n && (m_q.size() < DEPTH)));
    chk("drop_flag", 32'(drop_flag), 32'(m_drop));
  endtask

  initial begin
    rst_n = 1'b0; disp_en = 1'b0; disp_x = '0; disp_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    repeat (3) tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Release with no traffic: everything quiet, ready immediately.
    rst_n = 1'b1;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);
    chk("rel_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rel_mem_addr", 32'(mem_addr), 32'd0);
    repeat (3) tick();

    // Single display fetch at (5,2).
    disp_en = 1'b1; disp_x = 12'd5; disp_y = 12'd2;
    tick();
    disp_en = 1'b0;
    chk("fetch_addr", 32'(mem_addr), 32'd1285);
    tick(); tick();
    chk("fetch_pix", 32'(pix_rgb), 32'hABC);
    chk("fetch_pv", 32'(pix_valid), 32'd1);
    tick();

    // Display holds the port while host offers five writes.
    disp_en = 1'b1; disp_x = 12'd10; disp_y = 12'd10;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_x = 12'(i * 3); wr_y = 12'(i + 1); wr_data = 12'(12'h100 + i);
      tick();
    end
    wr_valid = 1'b0;
    chk("hold_level", 32'(fifo_level), 32'd4);
    chk("hold_ready", 32'(wr_ready), 32'd0);

    // Display released: FIFO drains in order.
    disp_en = 1'b0;
    repeat (6) tick();
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Out-of-range write dropped, then out-of-range display request.
    wr_valid = 1'b1; wr_x = 12'd640; wr_y = 12'd0; wr_data = 12'hFFF;
    tick();
    wr_valid = 1'b0;
    chk("drop_set", 32'(drop_flag), 32'd1);
    disp_en = 1'b1; disp_x = 12'd700; disp_y = 12'd0;
    tick();
    disp_en = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a drain with in-flight pixels.
    disp_en = 1'b1; disp_x = 12'd1; disp_y = 12'd1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_x = 12'(20 + i); wr_y = 12'd7; wr_data = 12'(12'h200 + i);
      tick();
    end
    wr_valid = 1'b0;
    disp_en = 1'b0;
    tick();
    chk("mid_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0; disp_en = 1'b1;
    tick();
    rst_n = 1'b1; disp_en = 1'b0;
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_drop", 32'(drop_flag), 32'd0);
    repeat (4) tick();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rst_n    = ($urandom % 250) != 0;
      disp_en  = ($urandom % 2) != 0;
      disp_x   = 12'($urandom % 700);
      disp_y   = 12'($urandom % 500);
      wr_valid = ($urandom % 3) != 0;
      wr_x     = 12'($urandom % 660);
      wr_y     = 12'($urandom % 490);
      wr_data  = 12'($urandom);
      tick();
    end
    rst_n = 1'b1; disp_en = 1'b0; wr_valid = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: host write FIFO entries (power of 2, 2..16).
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 clk25mhz  in  1  pixel clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 disp_en  in  1  display active-region fetch request, one pixel per cycle.
REQ-007 disp_x / disp_y  in  12 each  display pixel coordinates.
REQ-008 pix_rgb  out  12  RGB444 pixel to the VGA output.
REQ-009 pix_valid  out  1  pix_rgb belongs to a display request.
REQ-010 wr_valid  in  1  host write request.
REQ-011 wr_ready  out  1  host write accepted on wr_valid && wr_ready.
REQ-012 wr_x / wr_y  in  12 each  host pixel coordinates.
REQ-013 wr_data  in  12  host RGB444 pixel.
REQ-014 mem_addr  out  19  frame-buffer address, single-port RAM.
REQ-015 mem_we  out  1  RAM write strobe.
REQ-016 mem_wdata  out  12  RAM write data.
REQ-017 mem_rdata  in  12  RAM read data, valid one cycle after a read address.
REQ-018 fifo_level  out  5  current FIFO occupancy.
REQ-019 drop_flag  out  1  sticky: an out-of-range host write was discarded.

Function
REQ-020 The block SHALL share the single RAM port between display fetch and host writes, one access per cycle.
REQ-021 The display SHALL have absolute priority: in cycle N, grant = DISP if disp_en && disp_x<H_ACTIVE && disp_y<V_ACTIVE; else WR if FIFO non-empty; else NONE.
REQ-022 The grant state register (NONE/DISP/WR) SHALL be updated every cycle, and there is no hold or lock between cycles.
REQ-023 Address SHALL be y*H_ACTIVE + x, truncated to 19 bits, for both requesters.
REQ-024 mem_addr/mem_we/mem_wdata SHALL be registered and driven in cycle N+1 for the grant decided in N.
REQ-025 DISP grant: mem_we=0. WR grant: mem_we=1 with FIFO head data, and the head is popped at the end of cycle N.
REQ-026 NONE grant: mem_we=0, and mem_addr holds its previous value.
REQ-027 pix_valid in cycle N+3 SHALL equal disp_en from cycle N; fixed 3-cycle latency, fully pipelined.
REQ-028 pix_rgb in N+3 SHALL be mem_rdata (registered) for a DISP grant, otherwise 12'h000.
REQ-029 wr_ready SHALL be !full && rst_n, derived from registered state only, with no combinational path from wr_valid.
REQ-030 An accepted write with wr_x>=H_ACTIVE or wr_y>=V_ACTIVE SHALL NOT be pushed, and SHALL set drop_flag.
REQ-031 An accepted in-range write SHALL be pushed at the end of its cycle. There is no bypass, so it is eligible for grant the next cycle at the earliest.
REQ-032 Same-cycle push and pop SHALL leave fifo_level unchanged. Pop of an empty FIFO SHALL be impossible by construction.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and host writes SHALL reach RAM in acceptance order.
REQ-034 fifo_level SHALL range 0..FIFO_DEPTH, and full = (fifo_level==FIFO_DEPTH).

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL reset to: FIFO empty, fifo_level=0, grant=NONE, pipeline valids cleared, drop_flag=0.
REQ-036 Output values in that cycle SHALL be: pix_rgb=0, pix_valid=0, mem_addr=0, mem_we=0, mem_wdata=0, wr_ready=0.
REQ-037 Reset mid-operation SHALL discard FIFO contents and in-flight pixels, and mem_we SHALL be 0 in the cycle after the reset edge.
REQ-038 wr_ready SHALL be 1 in the first cycle with rst_n=1.

Verification
REQ-039 Reset release with no traffic -> all outputs 0, and wr_ready=1 in the first cycle after release.
REQ-040 disp_en=1, x=5, y=2 in N, RAM returns 12'hABC -> mem_addr=1285 with mem_we=0 at N+1, then pix_rgb=12'hABC with pix_valid=1 at N+3.
REQ-041 disp_en held 1 in range while 5 host writes are offered -> 4 accepted, fifo_level=4, wr_ready=0, no mem_we.
REQ-042 Continuing REQ-041, disp_en dropped -> the 4 writes reach RAM on consecutive cycles, in order, at correct addresses, and fifo_level returns to 0.
REQ-043 Host write x=640, y=0 -> accepted, fifo_level unchanged, drop_flag=1 until reset. Then disp_en with x=700 -> no display RAM read, the FIFO may drain, and pix_rgb=0 with pix_valid=1 at N+3.
REQ-044 rst_n=0 for one cycle with fifo_level=3 mid-drain -> fifo_level=0, mem_we=0 next cycle, drop_flag=0, and no stale pix_valid.
